// File: rtl/midi_tx.sv
// MIDI serial transmitter: pops bytes from an external FIFO and sends each
// as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on tx.
module midi_tx #(
    parameter int unsigned CLKS_PER_BIT = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       fifo_empty_n,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       fifo_oe_n,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] LAST_CNT     = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] PRE_LAST_CNT = 8'(CLKS_PER_BIT - 2);

    state_t     state;
    logic [7:0] baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       bit_end;

    // Last cycle of the current serial bit
    assign bit_end = (baud_cnt == LAST_CNT);

    // Frame sequencer; every output is registered and set alongside the
    // transition into the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            fifo_rd   <= 1'b0;
            fifo_oe_n <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && fifo_empty_n) begin
                        state     <= POP;
                        fifo_rd   <= 1'b1;
                        fifo_oe_n <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                POP: begin
                    state   <= LATCH;
                    fifo_rd <= 1'b0;
                end
                LATCH: begin
                    state     <= START;
                    shreg     <= fifo_data;
                    baud_cnt  <= '0;
                    fifo_oe_n <= 1'b1;
                    tx        <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // Next bit is shreg[1] because the shift lands this same edge
                            tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state     <= IDLE;
                        baud_cnt  <= '0;
                        byte_done <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        baud_cnt  <= baud_cnt + 8'd1;
                        // Raise one cycle early so the pulse sits on the final stop cycle
                        byte_done <= (baud_cnt == PRE_LAST_CNT);
                    end
                end
                default: begin
                    state     <= IDLE;
                    baud_cnt  <= '0;
                    bit_idx   <= '0;
                    tx        <= 1'b1;
                    fifo_rd   <= 1'b0;
                    fifo_oe_n <= 1'b1;
                    busy      <= 1'b0;
                    byte_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_tx.sv
// Testbench for midi_tx: FIFO model, frame-decoding monitor and scoreboard.
module tb_midi_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       fifo_empty_n;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       fifo_oe_n;
    logic       tx;
    logic       busy;
    logic       byte_done;

    midi_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fifo_empty_n (fifo_empty_n),
        .fifo_data    (fifo_data),
        .fifo_rd      (fifo_rd),
        .fifo_oe_n    (fifo_oe_n),
        .tx           (tx),
        .busy         (busy),
        .byte_done    (byte_done)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         gaps[$];

    int cyc         = 0;
    int rd_count    = 0;
    int frames_done = 0;
    int fall_cyc    = 0;
    int stray_bd    = 0;
    int in_frame    = 0;
    int idx         = 0;
    int gap         = 0;
    logic [FRAME-1:0] samp;
    logic [FRAME-1:0] bdv;
    logic             busy_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, frames=%0d", frames_done);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO model: a pop presents the head byte the following cycle; at all
    // other times the read bus carries noise so a late sample is visible.
    always @(posedge clk) begin
        if (reset_n && fifo_rd) begin
            rd_count++;
            total++;
            if (fifo_q.size() == 0 || fifo_oe_n !== 1'b0) begin
                bad++;
                $display("FAIL pop: fifo_rd with size=%0d oe_n=%b, expected nonempty and 0",
                         fifo_q.size(), fifo_oe_n);
                fifo_data <= 8'($urandom);
            end else begin
                fifo_data <= fifo_q.pop_front();
            end
        end else begin
            fifo_data <= 8'($urandom);
        end
    end

    always @(negedge clk) fifo_empty_n = (fifo_q.size() != 0);

    // Expected line level for cycle i of a frame carrying byte b
    function automatic logic [FRAME-1:0] wave_of(input logic [7:0] b);
        logic [FRAME-1:0] w;
        int bitn;
        for (int i = 0; i < FRAME; i++) begin
            bitn = i / CPB;
            if (bitn == 0)      w[i] = 1'b0;
            else if (bitn == 9) w[i] = 1'b1;
            else                w[i] = b[bitn-1];
        end
        return w;
    endfunction

    // Monitor: collects one tx sample per cycle from the falling edge and
    // checks the whole frame against the head of the scoreboard.
    always @(negedge clk) begin
        logic [7:0] eb;
        logic [FRAME-1:0] ew;
        logic [FRAME-1:0] ebd;
        if (!reset_n) begin
            in_frame = 0;
            idx      = 0;
            gap      = 0;
        end else if (in_frame == 0) begin
            if (tx === 1'b0) begin
                in_frame = 1;
                samp     = '0;
                bdv      = '0;
                bdv[0]   = byte_done;
                busy_err = (busy !== 1'b1);
                idx      = 1;
                fall_cyc = cyc;
                gaps.push_back(gap);
            end else begin
                if (byte_done !== 1'b0) stray_bd++;
                gap++;
            end
        end else begin
            samp[idx] = tx;
            bdv[idx]  = byte_done;
            if (busy !== 1'b1) busy_err = 1'b1;
            idx++;
            if (idx == FRAME) begin
                in_frame = 0;
                gap      = 0;
                frames_done++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame: unexpected frame got=%b expected=none", samp);
                end else begin
                    eb = exp_q.pop_front();
                    ew = wave_of(eb);
                    if (samp !== ew || busy_err) begin
                        bad++;
                        $display("FAIL frame %02h: got=%b busy_err=%b expected=%b busy_err=0",
                                 eb, samp, busy_err, ew);
                    end
                end
                ebd = '0;
                ebd[FRAME-1] = 1'b1;
                chk("byte_done_pos", 64'(bdv), 64'(ebd));
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        fifo_empty_n = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) begin
            total++;
            bad++;
            $display("FAIL wait_frames: frames=%0d expected=%0d", frames_done, target);
        end
        @(negedge clk);
    endtask

    task automatic wait_idx(input int target, input int budget);
        int n;
        n = 0;
        while (!(in_frame != 0 && idx >= target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(in_frame != 0 && idx >= target)) begin
            total++;
            bad++;
            $display("FAIL wait_idx: frame not reached, idx=%0d expected=%0d", idx, target);
        end
    endtask

    initial begin
        int rd0, f0, err_rd, err_tx, err_busy, push_cyc, n;
        reset_n      = 1'b0;
        enable       = 1'b0;
        fifo_empty_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 64'(tx), 64'd1);
        chk("reset_outs", 64'({fifo_rd, fifo_oe_n, busy, byte_done}), 64'b0100);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x90 with latency and pop count
        enable = 1'b1;
        rd0 = rd_count;
        @(negedge clk);
        push_cyc = cyc;
        push_byte(8'h90);
        wait_frames(1, 200);
        chk("single_latency", 64'(fall_cyc - push_cyc), 64'd3);
        chk("single_rd", 64'(rd_count - rd0), 64'd1);

        // Back-to-back 0x01..0x04
        repeat (5) @(negedge clk);
        rd0 = rd_count;
        f0  = frames_done;
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        wait_frames(f0 + 4, 400);
        repeat (20) @(negedge clk);
        chk("b2b_rd", 64'(rd_count - rd0), 64'd4);
        chk("b2b_frames", 64'(frames_done - f0), 64'd4);
        for (int i = 1; i <= 3; i++)
            chk("b2b_gap", 64'(gaps[gaps.size() - 1 - (3 - i)]), 64'd3);

        // Empty FIFO for 100 cycles
        rd0 = rd_count;
        err_tx = 0;
        err_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) err_tx++;
            if (busy !== 1'b0) err_busy++;
        end
        chk("empty_rd", 64'(rd_count - rd0), 64'd0);
        chk("empty_tx", 64'(err_tx), 64'd0);
        chk("empty_busy", 64'(err_busy), 64'd0);

        // Enable drop during DATA of 0x55, with 0x33 waiting in the FIFO
        rd0 = rd_count;
        f0  = frames_done;
        push_byte(8'h55);
        wait_idx(3 * CPB, 100);
        enable = 1'b0;
        push_byte(8'h33);
        wait_frames(f0 + 1, 200);
        repeat (60) @(negedge clk);
        chk("endrop_rd", 64'(rd_count - rd0), 64'd1);
        chk("endrop_frames", 64'(frames_done - f0), 64'd1);
        enable = 1'b1;
        wait_frames(f0 + 2, 200);
        chk("endrop_resume_rd", 64'(rd_count - rd0), 64'd2);

        // Data isolation: 0xA5 with the read bus scrambled after LATCH
        f0 = frames_done;
        push_byte(8'hA5);
        wait_frames(f0 + 1, 200);

        // Asynchronous reset mid-DATA
        push_byte(8'h5A);
        wait_idx(4 * CPB, 100);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_tx", 64'(tx), 64'd1);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_fifo", 64'({fifo_rd, fifo_oe_n}), 64'b01);
        exp_q.delete();
        fifo_q.delete();
        rd0 = rd_count;
        repeat (2) @(negedge clk);
        chk("async_hold", 64'({tx, busy, byte_done}), 64'b100);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", 64'({tx, busy}), 64'b10);
        chk("post_reset_rd", 64'(rd_count - rd0), 64'd0);

        // Randomized traffic with enable toggling
        f0 = frames_done;
        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(0, 60);
            repeat (n) begin
                @(negedge clk);
                if ($urandom_range(0, 9) == 0) enable = ~enable;
            end
            push_byte(8'($urandom));
        end
        enable = 1'b1;
        wait_frames(f0 + 30, 3000);
        repeat (10) @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("stray_byte_done", 64'(stray_bd), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
